// File: rtl/exp_req_arbiter.sv
// exp_req_arbiter: round-robin scheduler that shares one exponentiation engine
// among NREQ requesters.
//
// It accepts one operand pair at a time and drives the engine operands plus a
// one-cycle start. It waits for done, then returns the result to the
// originating requester over a valid/ready response channel.
//
// Ports:
//   clk, rst             clock and synchronous active-low reset (0 = reset)
//   req_valid/a/b        per-requester request; operands packed at [i*k +: k]
//   req_ready            one-hot accept strobe (combinational, IDLE only)
//   rsp_valid            one-hot response valid for the granted requester
//   rsp_c, rsp_err       shared result and timeout flag, qualified by rsp_valid
//   rsp_ready            per-requester response ready
//   eng_a/b, eng_start   engine operands and start pulse
//   eng_c, eng_done      engine result and completion
//   busy                 high whenever the scheduler is not idle
//
// Optional feature: define EXP_ARB_TIMEOUT_EN to enable a BUSY watchdog of
// TIMEOUT cycles that completes the job with rsp_c=0 and rsp_err=1.
module exp_req_arbiter #(
    parameter int unsigned k       = 16,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*k-1:0]   req_a,
    input  logic [NREQ*k-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [2*k-1:0]      rsp_c,
    output logic                rsp_err,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [k-1:0]        eng_a,
    output logic [k-1:0]        eng_b,
    output logic                eng_start,
    input  logic [2*k-1:0]      eng_c,
    input  logic                eng_done,
    output logic                busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || k < 1) begin : g_bad_param
        $error("exp_req_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StBusy,
        StResp
    } state_e;

    state_e          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   id;
    logic [IW-1:0]   grant_id;
    logic [IW-1:0]   cand;
    logic            grant_found;
    logic [k-1:0]    sel_a;
    logic [k-1:0]    sel_b;

`ifdef EXP_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   tmo_cnt;
    logic            err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Search starts one past the last served requester, so it has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IW'((32'(rr_ptr) + i) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == StIdle && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign sel_a = req_a[grant_id * k +: k];
    assign sel_b = req_b[grant_id * k +: k];
    assign busy  = (state != StIdle);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= StIdle;
            rr_ptr    <= IW'(NREQ - 1);
            id        <= '0;
            rsp_valid <= '0;
            rsp_c     <= '0;
            eng_a     <= '0;
            eng_b     <= '0;
            eng_start <= 1'b0;
`ifdef EXP_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            eng_start <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (grant_found) begin
                        eng_a     <= sel_a;
                        eng_b     <= sel_b;
                        id        <= grant_id;
                        eng_start <= 1'b1;
                        state     <= StLaunch;
                    end
                end
                StLaunch: begin
`ifdef EXP_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state <= StBusy;
                end
                StBusy: begin
                    if (eng_done) begin
                        rsp_c         <= eng_c;
                        rsp_valid[id] <= 1'b1;
                        state         <= StResp;
`ifdef EXP_ARB_TIMEOUT_EN
                        err_q         <= 1'b0;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        // Counter would reach TIMEOUT at this edge: give up.
                        rsp_c         <= '0;
                        err_q         <= 1'b1;
                        rsp_valid[id] <= 1'b1;
                        state         <= StResp;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                StResp: begin
                    if (rsp_ready[id]) begin
                        rr_ptr    <= id;
                        rsp_valid <= '0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_req_arbiter.sv
// Testbench for exp_req_arbiter: directed scenarios plus a randomized phase,
// all checked cycle by cycle against a transaction-level reference model.
module tb_exp_req_arbiter;

    localparam int unsigned K       = 16;
    localparam int unsigned CW      = 2 * K;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 50;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*K-1:0]   req_a = '0;
    logic [NREQ*K-1:0]   req_b = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [CW-1:0]       rsp_c;
    logic                rsp_err;
    logic [NREQ-1:0]     rsp_ready = '0;
    logic [K-1:0]        eng_a;
    logic [K-1:0]        eng_b;
    logic                eng_start;
    logic [CW-1:0]       eng_c = '0;
    logic                eng_done = 1'b0;
    logic                busy;

    always #5 clk = ~clk;

    exp_req_arbiter #(
        .k       (K),
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_c     (rsp_c),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_start (eng_start),
        .eng_c     (eng_c),
        .eng_done  (eng_done),
        .busy      (busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Requester stimulus.
    logic [NREQ-1:0] rv   = '0;
    logic [NREQ-1:0] rrdy = '1;
    logic [K-1:0]    ra [NREQ];
    logic [K-1:0]    rb [NREQ];
    bit              rand_mode = 1'b0;

    // Engine model: done eng_lat cycles after the start cycle; 0 means never.
    int              eng_lat  = 20;
    bit              eng_pend = 1'b0;
    int              eng_fire = 0;
    logic [K-1:0]    ea, eb;

    // Reference model: one outstanding job, round-robin pointer.
    bit              job = 1'b0;
    int              jid, acc, resp_cyc;
    bit              done_seen, jerr;
    logic [CW-1:0]   jc;
    logic [K-1:0]    ja, jb;
    int              ref_last = NREQ - 1;
    bit              post_rst = 1'b0;
    int              grant_log[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [CW-1:0] pow_ref(input logic [K-1:0] a, input logic [K-1:0] b);
        logic [CW-1:0] r;
        r = 1;
        for (int i = 0; i < int'(b); i++) r = r * CW'(a);
        return r;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        for (int j = 1; j <= NREQ; j++) begin
            int idx;
            idx = (last + j) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock cycle: drive at the falling edge, check 1 time unit later.
    task automatic tick();
        logic [NREQ-1:0] exp_rr;
        logic [NREQ-1:0] exp_rv;
        int g;
        @(negedge clk);
        cyc++;
        eng_done = 1'b0;
        eng_c    = CW'({$urandom, $urandom});
        if (eng_pend && cyc == eng_fire) begin
            eng_done = 1'b1;
            eng_c    = pow_ref(ea, eb);
            eng_pend = 1'b0;
        end
        if (eng_start === 1'b1) begin
            ea = eng_a;
            eb = eng_b;
            if (rand_mode) eng_lat = $urandom_range(2, 12);
            if (eng_lat != 0) begin
                eng_pend = 1'b1;
                eng_fire = cyc + eng_lat;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rv[i] && $urandom_range(0, 15) == 0) begin
                    rv[i] = 1'b0;
                end else if (!rv[i] && $urandom_range(0, 3) == 0) begin
                    rv[i] = 1'b1;
                    ra[i] = K'($urandom_range(0, 300));
                    rb[i] = K'($urandom_range(0, 6));
                end
                rrdy[i] = ($urandom_range(0, 2) != 0);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]      = rv[i];
            req_a[i*K +: K]   = ra[i];
            req_b[i*K +: K]   = rb[i];
        end
        rsp_ready = rrdy;
        #1;
        if (!rst) begin
            job      = 1'b0;
            ref_last = NREQ - 1;
            post_rst = 1'b1;
            return;
        end
        if (post_rst) begin
            check_eq("rst_eng_a", eng_a, 0);
            check_eq("rst_eng_b", eng_b, 0);
            check_eq("rst_rsp_c", rsp_c, 0);
            check_eq("rst_rsp_err", rsp_err, 0);
            post_rst = 1'b0;
        end
        exp_rr = '0;
        g = -1;
        if (!job) begin
            g = pick(rv, ref_last);
            if (g >= 0) exp_rr[g] = 1'b1;
        end
        check_eq("req_ready", req_ready, exp_rr);
        check_eq("eng_start", eng_start, job && (cyc == acc + 1));
        check_eq("busy", busy, job);
        if (job) begin
            check_eq("eng_a", eng_a, ja);
            check_eq("eng_b", eng_b, jb);
        end
        exp_rv = '0;
        if (job && done_seen && cyc >= resp_cyc) exp_rv[jid] = 1'b1;
        check_eq("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv != 0) begin
            check_eq("rsp_c", rsp_c, jc);
            check_eq("rsp_err", rsp_err, jerr);
        end
        if (job) begin
            if (!done_seen && cyc >= acc + 2) begin
                if (eng_done) begin
                    done_seen = 1'b1;
                    jerr      = 1'b0;
                    jc        = pow_ref(ja, jb);
                    resp_cyc  = cyc + 1;
                end
`ifdef EXP_ARB_TIMEOUT_EN
                else if (cyc == acc + 1 + TIMEOUT) begin
                    done_seen = 1'b1;
                    jerr      = 1'b1;
                    jc        = '0;
                    resp_cyc  = cyc + 1;
                end
`endif
            end else if (done_seen && cyc >= resp_cyc && rrdy[jid]) begin
                job      = 1'b0;
                ref_last = jid;
            end
        end else if (g >= 0) begin
            job       = 1'b1;
            jid       = g;
            ja        = ra[g];
            jb        = rb[g];
            acc       = cyc;
            done_seen = 1'b0;
            grant_log.push_back(g);
            rv[g]     = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int idx, input int max_cyc, output int t_acc,
                            output int t_rsp, output logic [CW-1:0] c, output logic e);
        t_acc = -1;
        t_rsp = -1;
        c     = '0;
        e     = 1'b0;
        for (int n = 0; n < max_cyc && t_rsp < 0; n++) begin
            tick();
            if (t_acc < 0 && req_ready[idx]) t_acc = cyc;
            if (rsp_valid[idx]) begin
                t_rsp = cyc;
                c     = rsp_c;
                e     = rsp_err;
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 200 && (job || rv != 0); n++) tick();
        check_eq(tag, job, 0);
    endtask

    initial begin
        int              t_acc, t_rsp, seen;
        logic [CW-1:0]   c;
        logic            e;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end

        // Reset; the cycle after release checks every output is zero.
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // All four at once: rotation 0,1,2,3 from reset.
        eng_lat = 6;
        ra[0] = 2; rb[0] = 3;
        ra[1] = 2; rb[1] = 10;
        ra[2] = 5; rb[2] = 3;
        ra[3] = 3; rb[3] = 4;
        rv = '1;
        grant_log.delete();
        seen = 0;
        for (int n = 0; n < 200 && (job || rv != 0); n++) begin
            tick();
            if (rsp_valid[1]) seen = int'(rsp_c);
        end
        check_eq("all4_count", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++)
            check_eq("all4_order", grant_log[i], i);
        check_eq("all4_r1_pow", seen, 1024);

        // Wrap-around after serving 3: requesters 1 and 3 -> 1 then 3.
        ra[1] = 6; rb[1] = 2;
        ra[3] = 4; rb[3] = 3;
        rv = 4'b1010;
        grant_log.delete();
        drain("wrap_drain");
        check_eq("wrap_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check_eq("wrap_first", grant_log[0], 1);
            check_eq("wrap_second", grant_log[1], 3);
        end

        // Single request from requester 2, engine done 20 cycles after start.
        eng_lat = 20;
        ra[2] = 3; rb[2] = 5;
        rv[2] = 1'b1;
        wait_rsp(2, 60, t_acc, t_rsp, c, e);
        check_eq("single_latency", t_rsp - t_acc, 22);
        check_eq("single_c", c, 243);
        check_eq("single_err", e, 0);
        drain("single_drain");

        // Response backpressure on requester 0 while requester 1 waits.
        eng_lat = 4;
        rrdy[0] = 1'b0;
        ra[0] = 4; rb[0] = 2;
        rv[0] = 1'b1;
        wait_rsp(0, 40, t_acc, t_rsp, c, e);
        check_eq("bp_rsp_seen", t_rsp >= 0, 1);
        ra[1] = 2; rb[1] = 2;
        rv[1] = 1'b1;
        for (int n = 0; n < 7; n++) begin
            tick();
            check_eq("bp_hold_c", rsp_c, 16);
            check_eq("bp_no_grant", req_ready, 0);
            check_eq("bp_busy", busy, 1);
        end
        rrdy[0] = 1'b1;
        tick();
        tick();
        check_eq("bp_release_grant", req_ready, 4'b0010);
        drain("bp_drain");

        // Reset in the middle of BUSY; the late done must be ignored.
        eng_lat = 30;
        ra[3] = 9; rb[3] = 2;
        rv[3] = 1'b1;
        t_acc = -1;
        for (int n = 0; n < 20 && t_acc < 0; n++) begin
            tick();
            if (req_ready[3]) t_acc = cyc;
        end
        check_eq("rst_mid_grant", t_acc >= 0, 1);
        while (cyc < t_acc + 9) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (rsp_valid != 0) seen++;
        end
        check_eq("rst_mid_no_rsp", seen, 0);
        eng_lat = 8;
        ra[0] = 7; rb[0] = 3;
        rv[0] = 1'b1;
        wait_rsp(0, 40, t_acc, t_rsp, c, e);
        check_eq("rst_mid_fresh_c", c, 343);
        drain("rst_mid_drain");

        // Randomized traffic with random backpressure and engine latency.
        rand_mode = 1'b1;
        for (int n = 0; n < 3000; n++) tick();
        rand_mode = 1'b0;
        rv   = '0;
        rrdy = '1;
        drain("rand_drain");

        // Engine that never completes.
        eng_lat = 0;
        ra[1] = 2; rb[1] = 2;
        rv[1] = 1'b1;
`ifdef EXP_ARB_TIMEOUT_EN
        wait_rsp(1, 80, t_acc, t_rsp, c, e);
        check_eq("tmo_latency", t_rsp - t_acc, 52);
        check_eq("tmo_err", e, 1);
        check_eq("tmo_c", c, 0);
        drain("tmo_drain");
`else
        seen = 0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (rsp_valid != 0) seen++;
        end
        check_eq("hang_busy", busy, 1);
        check_eq("hang_no_rsp", seen, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
